esm_issue_select: RTL and testbench

//  Consumer side of the ESM dependency-analysis core. Owns the slot state of the
//  bs-entry instruction buffer and allocates slots to incoming instructions; its

---
 rtl/esm_pkg.sv | 14 +
 rtl/esm_rr_pick.sv | 35 +++
 rtl/esm_issue_select.sv | 125 ++++++++++++
 tb/tb_esm_issue_select.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/esm_pkg.sv
// Shared types and sizing for the ESM issue-select slice.
package esm_pkg;

    localparam int BS_DEFAULT = 16;
    localparam int IW         = $clog2(BS_DEFAULT);

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        SETTLE = 2'd1,
        WAIT   = 2'd2,
        ISSUED = 2'd3
    } slot_state_t;

endpackage

// File: rtl/esm_rr_pick.sv
// Rotating-priority picker: first set request at or after base, wrapping around.
module esm_rr_pick #(
    parameter int bs    = 16,
    parameter int IDX_W = $clog2(bs)
) (
    input  logic [0:bs-1]      req,
    input  logic [IDX_W-1:0]   base,
    output logic               grant_valid,
    output logic [IDX_W-1:0]   grant_index
);

    logic [0:bs-1]    rot;
    logic [IDX_W-1:0] offset;

    // rot[k] is the request of the slot k positions after base
    generate
        for (genvar gi = 0; gi < bs; gi++) begin : g_rot
            assign rot[gi] = req[base + IDX_W'(gi)];
        end
    endgenerate

    always_comb begin
        grant_valid = 1'b0;
        offset      = '0;
        for (int k = bs - 1; k >= 0; k--) begin
            if (rot[k]) begin
                grant_valid = 1'b1;
                offset      = IDX_W'(k);
            end
        end
    end

    assign grant_index = base + offset;

endmodule

// File: rtl/esm_issue_select.sv
// Slot allocator and oldest-first issue selector sitting behind the ESM dependency core.
module esm_issue_select
    import esm_pkg::*;
#(
    parameter int bs    = BS_DEFAULT,
    parameter int CNT_W = $clog2(bs) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    alloc_valid,
    output logic                    alloc_ready,
    output logic [$clog2(bs)-1:0]   buffer_index,
    output logic [0:bs-1]           valid_entries,
    input  logic [0:bs-1]           independent_instr,
    output logic                    issue_valid,
    input  logic                    issue_ready,
    output logic [$clog2(bs)-1:0]   issue_index,
    input  logic                    done_valid,
    input  logic [$clog2(bs)-1:0]   done_index,
    output logic [CNT_W-1:0]        occupancy,
    output logic                    err_bad_done
);

    localparam int IDX_W = $clog2(bs);

    slot_state_t      state_reg  [bs];
    slot_state_t      state_next [bs];
    logic [0:bs-1]    valid_entries_reg;
    logic [0:bs-1]    eligible;
    logic [IDX_W-1:0] head_reg, tail_reg;
    logic             issue_valid_reg;
    logic [IDX_W-1:0] issue_index_reg;
    logic [CNT_W-1:0] occupancy_reg;
    logic             err_reg;

    logic             alloc_fire;
    logic             issue_fire;
    logic             issue_load;
    logic             done_ok;
    logic             grant_valid;
    logic [IDX_W-1:0] grant_index;

    assign alloc_ready = (state_reg[tail_reg] == FREE);
    assign alloc_fire  = alloc_valid & alloc_ready;
    assign issue_fire  = issue_valid_reg & issue_ready;
    assign issue_load  = ~issue_valid_reg | issue_fire;
    assign done_ok     = done_valid & (state_reg[done_index] == ISSUED);

    // Each state admits exactly one kind of event, so per-slot updates never collide.
    generate
        for (genvar gi = 0; gi < bs; gi++) begin : g_slot
            always_comb begin
                state_next[gi] = state_reg[gi];
                case (state_reg[gi])
                    FREE:    if (alloc_fire && tail_reg == IDX_W'(gi)) state_next[gi] = SETTLE;
                    SETTLE:  state_next[gi] = WAIT;
                    WAIT:    if (issue_fire && issue_index_reg == IDX_W'(gi)) state_next[gi] = ISSUED;
                    ISSUED:  if (done_ok && done_index == IDX_W'(gi)) state_next[gi] = FREE;
                    default: state_next[gi] = FREE;
                endcase
            end

            // The slot firing now must not be picked again for the next issue.
            assign eligible[gi] = (state_reg[gi] == WAIT) && independent_instr[gi]
                                  && !(issue_fire && issue_index_reg == IDX_W'(gi));

            always_ff @(posedge clk) begin
                if (rst) begin
                    state_reg[gi]         <= FREE;
                    valid_entries_reg[gi] <= 1'b0;
                end else begin
                    state_reg[gi]         <= state_next[gi];
                    valid_entries_reg[gi] <= (state_next[gi] != FREE);
                end
            end
        end
    endgenerate

    esm_rr_pick #(
        .bs    (bs),
        .IDX_W (IDX_W)
    ) u_pick (
        .req         (eligible),
        .base        (head_reg),
        .grant_valid (grant_valid),
        .grant_index (grant_index)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            head_reg        <= '0;
            tail_reg        <= '0;
            issue_valid_reg <= 1'b0;
            issue_index_reg <= '0;
            occupancy_reg   <= '0;
            err_reg         <= 1'b0;
        end else begin
            if (alloc_fire) begin
                tail_reg <= tail_reg + 1'b1;
            end
            // Head only steers priority, so a lagging head is harmless.
            if (state_reg[head_reg] == FREE && head_reg != tail_reg) begin
                head_reg <= head_reg + 1'b1;
            end
            if (issue_load) begin
                issue_valid_reg <= grant_valid;
                if (grant_valid) begin
                    issue_index_reg <= grant_index;
                end
            end
            occupancy_reg <= occupancy_reg + CNT_W'(alloc_fire) - CNT_W'(done_ok);
            if (done_valid && !done_ok) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign buffer_index  = tail_reg;
    assign valid_entries = valid_entries_reg;
    assign issue_valid   = issue_valid_reg;
    assign issue_index   = issue_index_reg;
    assign occupancy     = occupancy_reg;
    assign err_bad_done  = err_reg;

endmodule

// File: tb/tb_esm_issue_select.sv
// Directed bench for esm_issue_select; vectors print slot 0 as the leftmost hex digit.
module tb_esm_issue_select;

    localparam int BS = 16;
    localparam int IW = 4;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          alloc_valid;
    logic          alloc_ready;
    logic [IW-1:0] buffer_index;
    logic [0:BS-1] valid_entries;
    logic [0:BS-1] independent_instr;
    logic          issue_valid;
    logic          issue_ready;
    logic [IW-1:0] issue_index;
    logic          done_valid;
    logic [IW-1:0] done_index;
    logic [CW-1:0] occupancy;
    logic          err_bad_done;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    esm_issue_select #(.bs(BS), .CNT_W(CW)) dut (
        .clk               (clk),
        .rst               (rst),
        .alloc_valid       (alloc_valid),
        .alloc_ready       (alloc_ready),
        .buffer_index      (buffer_index),
        .valid_entries     (valid_entries),
        .independent_instr (independent_instr),
        .issue_valid       (issue_valid),
        .issue_ready       (issue_ready),
        .issue_index       (issue_index),
        .done_valid        (done_valid),
        .done_index        (done_index),
        .occupancy         (occupancy),
        .err_bad_done      (err_bad_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end else begin
            $display("ok   %s: 0x%0h", tag, obs);
        end
    endtask

    // Advance one clock; outputs are observed on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        alloc_valid = 1'b0;
        issue_ready = 1'b0;
        done_valid = 1'b0;
        done_index = '0;
        independent_instr = '0;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        alloc_valid = 1'b0;
        issue_ready = 1'b0;
        done_valid = 1'b0;
        done_index = '0;
        independent_instr = '0;
        step();
        step();
        check("rst_issue_valid", issue_valid, 0);
        check("rst_issue_index", issue_index, 0);
        check("rst_occupancy", occupancy, 0);
        check("rst_err", err_bad_done, 0);
        check("rst_valid_entries", valid_entries, 0);
        check("rst_alloc_ready", alloc_ready, 1);
        check("rst_buffer_index", buffer_index, 0);
        rst = 1'b0;

        // 1: three allocations, all independent, execute always ready
        independent_instr = 16'hFFFF;
        issue_ready = 1'b1;
        alloc_valid = 1'b1;
        step(); check("t1_e1_iv", issue_valid, 0);
        step(); check("t1_e2_iv", issue_valid, 0);
        step(); check("t1_e3_iv", issue_valid, 1); check("t1_e3_idx", issue_index, 0);
        alloc_valid = 1'b0;
        step(); check("t1_e4_iv", issue_valid, 1); check("t1_e4_idx", issue_index, 1);
        step(); check("t1_e5_iv", issue_valid, 1); check("t1_e5_idx", issue_index, 2);
        step(); check("t1_e6_iv", issue_valid, 0);
        check("t1_occ", occupancy, 3);
        check("t1_ve", valid_entries, 32'hE000);

        // 2: fill every slot, then free slot 0 and refill it
        do_reset();
        alloc_valid = 1'b1;
        for (int i = 0; i < BS; i++) step();
        check("t2_full_ready", alloc_ready, 0);
        check("t2_full_occ", occupancy, 16);
        check("t2_full_ve", valid_entries, 32'hFFFF);
        check("t2_full_bidx", buffer_index, 0);
        independent_instr = 16'h8000;
        issue_ready = 1'b1;
        step(); check("t2_iv", issue_valid, 1); check("t2_idx", issue_index, 0);
        step(); check("t2_iv_after_fire", issue_valid, 0);
        check("t2_occ_still_full", occupancy, 16);
        independent_instr = '0;
        issue_ready = 1'b0;
        done_valid = 1'b1;
        done_index = 4'd0;
        check("t2_ready_in_done_cycle", alloc_ready, 0);
        step();
        done_valid = 1'b0;
        check("t2_occ_after_done", occupancy, 15);
        check("t2_ready_after_done", alloc_ready, 1);
        check("t2_bidx_wrapped", buffer_index, 0);
        step();
        check("t2_occ_refilled", occupancy, 16);
        check("t2_ready_refilled", alloc_ready, 0);
        check("t2_ve_refilled", valid_entries, 32'hFFFF);
        alloc_valid = 1'b0;

        // 3: only slots 2 and 3 independent, then slot 0
        do_reset();
        issue_ready = 1'b1;
        alloc_valid = 1'b1;
        for (int i = 0; i < 4; i++) step();
        alloc_valid = 1'b0;
        step();
        step();
        check("t3_iv_idle", issue_valid, 0);
        independent_instr = 16'h3000;
        step(); check("t3_a_iv", issue_valid, 1); check("t3_a_idx", issue_index, 2);
        step(); check("t3_b_iv", issue_valid, 1); check("t3_b_idx", issue_index, 3);
        step(); check("t3_c_iv", issue_valid, 0);
        independent_instr = 16'hB000;
        step(); check("t3_d_iv", issue_valid, 1); check("t3_d_idx", issue_index, 0);
        step(); check("t3_e_iv", issue_valid, 0);

        // 4: stall with execute not ready while another slot becomes eligible
        issue_ready = 1'b0;
        independent_instr = 16'h4800;
        alloc_valid = 1'b1;
        step();
        alloc_valid = 1'b0;
        check("t4_h1_iv", issue_valid, 1); check("t4_h1_idx", issue_index, 1);
        for (int i = 2; i <= 5; i++) begin
            step();
            check($sformatf("t4_h%0d_iv", i), issue_valid, 1);
            check($sformatf("t4_h%0d_idx", i), issue_index, 1);
        end
        issue_ready = 1'b1;
        step(); check("t4_rel_iv", issue_valid, 1); check("t4_rel_idx", issue_index, 4);
        step(); check("t4_end_iv", issue_valid, 0);
        check("t4_occ", occupancy, 5);

        // 5: alloc slot 6, fire slot 5 and complete slot 0 in one cycle
        issue_ready = 1'b0;
        independent_instr = 16'h0400;
        alloc_valid = 1'b1;
        step();
        alloc_valid = 1'b0;
        step();
        step(); check("t5_pre_iv", issue_valid, 1); check("t5_pre_idx", issue_index, 5);
        check("t5_pre_occ", occupancy, 6);
        alloc_valid = 1'b1;
        issue_ready = 1'b1;
        done_valid = 1'b1;
        done_index = 4'd0;
        check("t5_bidx", buffer_index, 6);
        step();
        alloc_valid = 1'b0;
        issue_ready = 1'b0;
        done_valid = 1'b0;
        check("t5_occ", occupancy, 6);
        check("t5_ve", valid_entries, 32'h7E00);
        check("t5_iv", issue_valid, 0);
        check("t5_err", err_bad_done, 0);

        // 6: completion for a WAIT slot is flagged and leaves it waiting; then reset
        step();
        done_valid = 1'b1;
        done_index = 4'd6;
        step();
        done_valid = 1'b0;
        check("t6_err", err_bad_done, 1);
        check("t6_ve", valid_entries, 32'h7E00);
        check("t6_occ", occupancy, 6);
        independent_instr = 16'h0200;
        step(); check("t6_still_wait_iv", issue_valid, 1); check("t6_still_wait_idx", issue_index, 6);
        check("t6_err_sticky", err_bad_done, 1);
        rst = 1'b1;
        alloc_valid = 1'b1;
        done_valid = 1'b1;
        done_index = 4'd1;
        step();
        check("t6_rst_iv", issue_valid, 0);
        check("t6_rst_idx", issue_index, 0);
        check("t6_rst_occ", occupancy, 0);
        check("t6_rst_err", err_bad_done, 0);
        check("t6_rst_ve", valid_entries, 0);
        check("t6_rst_bidx", buffer_index, 0);
        rst = 1'b0;
        alloc_valid = 1'b0;
        done_valid = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1, "timeout");
    end

endmodule
